// File: rtl/score_display_mux.sv
// score_display_mux: drives a 4-digit common-anode 7-segment display as
// [P1][-][-][P2]. The scores come from another clock domain and are resynchronised
// here. Each player's digit flashes for a while after that player's score changes.
// Handshake note: there is no valid/ready traffic here; the scores are level
// signals and are sampled every clock.
module score_display_mux #(
   parameter int SCAN_DIV     = 100_000,
   parameter int FLASH_HALF   = 5_000_000,
   parameter int FLASH_PHASES = 6
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] p1_score,
   input  logic [3:0] p2_score,
   input  logic       en,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int PW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CW  = $clog2(FLASH_HALF + 1);
   localparam int PHW = $clog2(FLASH_PHASES + 1);

   localparam logic [6:0] SEG_DASH = 7'b0111111;

   // Player index 0 is P1 and player index 1 is P2.
   logic [3:0]     sc_in     [2];
   logic [3:0]     s1        [2];
   logic [3:0]     s2        [2];
   logic [3:0]     s3        [2];
   logic [3:0]     held      [2];
   logic [3:0]     held_prev [2];

   logic           fl_active [2];
   logic [PHW-1:0] fl_phase  [2];
   logic [CW-1:0]  fl_cnt    [2];
   logic [1:0]     blank;

   logic [PW-1:0]  prescale;
   logic [1:0]     idx;

   logic [3:0]     an_d;
   logic [6:0]     seg_d;

   assign sc_in[0] = p1_score;
   assign sc_in[1] = p2_score;
   assign dp       = 1'b1;

   // Active-low gfedcba segment patterns. Values 10..15 show 'E'.
   function automatic logic [6:0] seg_decode(input logic [3:0] v);
      logic [6:0] r;
      case (v)
         4'd0:    r = 7'b1000000;
         4'd1:    r = 7'b1111001;
         4'd2:    r = 7'b0100100;
         4'd3:    r = 7'b0110000;
         4'd4:    r = 7'b0011001;
         4'd5:    r = 7'b0010010;
         4'd6:    r = 7'b0000010;
         4'd7:    r = 7'b1111000;
         4'd8:    r = 7'b0000000;
         4'd9:    r = 7'b0010000;
         default: r = 7'b0000110;
      endcase
      return r;
   endfunction

   // Three-flop resync; held only takes a value that looked the same on two samples.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int p = 0; p < 2; p++) begin
            s1[p]        <= '0;
            s2[p]        <= '0;
            s3[p]        <= '0;
            held[p]      <= '0;
            held_prev[p] <= '0;
         end
      end else begin
         for (int p = 0; p < 2; p++) begin
            s1[p]        <= sc_in[p];
            s2[p]        <= s1[p];
            s3[p]        <= s2[p];
            if (s2[p] == s3[p]) held[p] <= s3[p];
            held_prev[p] <= held[p];
         end
      end
   end

   // Scan prescaler and digit index; they run regardless of en.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prescale <= '0;
         idx      <= '0;
      end else if (prescale == PW'(SCAN_DIV - 1)) begin
         prescale <= '0;
         idx      <= idx + 2'd1;
      end else begin
         prescale <= prescale + PW'(1);
      end
   end

   // Flash timers. A held change (re)starts the timer. The timer stops after the last phase.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int p = 0; p < 2; p++) begin
            fl_active[p] <= 1'b0;
            fl_phase[p]  <= '0;
            fl_cnt[p]    <= '0;
         end
      end else begin
         for (int p = 0; p < 2; p++) begin
            if (held[p] != held_prev[p]) begin
               fl_active[p] <= 1'b1;
               fl_phase[p]  <= '0;
               fl_cnt[p]    <= '0;
            end else if (fl_active[p]) begin
               if (fl_cnt[p] == CW'(FLASH_HALF - 1)) begin
                  fl_cnt[p]   <= '0;
                  fl_phase[p] <= fl_phase[p] + PHW'(1);
                  if (fl_phase[p] == PHW'(FLASH_PHASES - 1)) fl_active[p] <= 1'b0;
               end else begin
                  fl_cnt[p] <= fl_cnt[p] + CW'(1);
               end
            end
         end
      end
   end

   // A player's digit is dark during the even phases of an active flash.
   always_comb begin
      blank = 2'b00;
      for (int p = 0; p < 2; p++) begin
         blank[p] = fl_active[p] & ~fl_phase[p][0];
      end
   end

   // Choose the anode and segment pattern for the digit now being scanned.
   always_comb begin
      an_d  = 4'b1111;
      seg_d = SEG_DASH;
      case (idx)
         2'd3: begin
            seg_d = seg_decode(held[0]);
            if (en && !blank[0]) an_d = 4'b0111;
         end
         2'd2: begin
            if (en) an_d = 4'b1011;
         end
         2'd1: begin
            if (en) an_d = 4'b1101;
         end
         default: begin
            seg_d = seg_decode(held[1]);
            if (en && !blank[1]) an_d = 4'b1110;
         end
      endcase
   end

   // Register the display outputs so they are glitch-free.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         an  <= 4'b1111;
         seg <= 7'h7F;
      end else begin
         an  <= an_d;
         seg <= seg_d;
      end
   end

endmodule

// File: tb/tb_score_display_mux.sv
// Bench for score_display_mux. It uses small parameters. The expected display is
// computed each cycle from the input history: scan position, stable-sample rule
// and flash windows.
module tb_score_display_mux;

  localparam int SD   = 4;
  localparam int FH   = 8;
  localparam int FP   = 4;
  localparam int MAXC = 4096;

  logic       clk;
  logic       reset;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic       en;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int errors;
  int checks;

  // reference model state (index = cycles since reset release + 4)
  int         cyc;
  logic [3:0] in_h   [2][MAXC+8];
  logic [3:0] held_h [2][MAXC+8];
  int         start  [2];
  logic [3:0] exp_an;
  logic [6:0] exp_seg;

  score_display_mux #(.SCAN_DIV(SD), .FLASH_HALF(FH), .FLASH_PHASES(FP)) dut (
    .clk(clk), .reset(reset), .p1_score(p1_score), .p2_score(p2_score),
    .en(en), .an(an), .seg(seg), .dp(dp)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] dec(input logic [3:0] v);
    logic [6:0] t [10];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
          7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    if (v > 4'd9) return 7'b0000110;
    return t[v];
  endfunction

  task automatic model_reset();
    cyc = 0;
    for (int p = 0; p < 2; p++) begin
      start[p] = -1;
      for (int k = 0; k < MAXC + 8; k++) begin
        in_h[p][k]   = 4'd0;
        held_h[p][k] = 4'd0;
      end
    end
  endtask

  // Advance one clock, update the model, and return at the falling edge ready for checking.
  task automatic step();
    int i, e, idx, ph;
    logic [1:0] blk;
    @(posedge clk);
    if (cyc >= MAXC) begin
      $display("FAIL model_budget cyc=%0d limit=%0d", cyc, MAXC);
      $fatal(1);
    end
    cyc++;
    i = cyc + 4;
    in_h[0][i] = p1_score;
    in_h[1][i] = p2_score;
    for (int p = 0; p < 2; p++)
      held_h[p][i] = (in_h[p][i-2] == in_h[p][i-3]) ? in_h[p][i-3] : held_h[p][i-1];
    idx = ((cyc - 1) / SD) % 4;
    blk = 2'b00;
    for (int p = 0; p < 2; p++) begin
      if (start[p] >= 0) begin
        e  = cyc - 1 - start[p];
        ph = e / FH;
        if (ph < FP && ph % 2 == 0) blk[p] = 1'b1;
      end
    end
    if (idx == 3)      exp_seg = dec(held_h[0][i-1]);
    else if (idx == 0) exp_seg = dec(held_h[1][i-1]);
    else               exp_seg = 7'b0111111;
    exp_an = 4'b1111;
    if (en && !(idx == 3 && blk[0]) && !(idx == 0 && blk[1]))
      exp_an = ~(4'b0001 << idx);
    for (int p = 0; p < 2; p++)
      if (held_h[p][i-1] != held_h[p][i-2]) start[p] = cyc;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; p1_score = 4'd0; p2_score = 4'd0; en = 1'b1;
    #12;
    checks++;
    if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1) begin
      errors++; $display("FAIL reset_init an=%b seg=%b dp=%b want 1111/1111111/1", an, seg, dp);
    end
    @(negedge clk); reset = 1'b0; model_reset();
    for (int k = 0; k < 6; k++) step();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1) begin
      errors++; $display("FAIL reset_async an=%b seg=%b dp=%b want 1111/1111111/1", an, seg, dp);
    end
    @(negedge clk); @(negedge clk); reset = 1'b0; model_reset();
    for (int k = 1; k <= 32; k++) begin
      logic [3:0] want;
      step();
      want = ~(4'b0001 << (((k - 1) / 4) % 4));
      checks++;
      if (an !== want || an !== exp_an) begin
        errors++; $display("FAIL reset_scan k=%0d an=%b want %b", k, an, want);
      end
    end
  endtask

  task automatic test_static();
    p1_score = 4'd3; p2_score = 4'd7;
    for (int k = 0; k < 48; k++) begin
      step();
      checks++;
      if (an !== exp_an || (exp_an != 4'hF && seg !== exp_seg) || dp !== 1'b1) begin
        errors++; $display("FAIL static cyc=%0d an=%b seg=%b want %b %b", cyc, an, seg, exp_an, exp_seg);
      end
    end
    for (int k = 0; k < 16; k++) begin
      logic [6:0] want;
      step();
      case (an)
        4'b0111: want = 7'b0110000;
        4'b1011: want = 7'b0111111;
        4'b1101: want = 7'b0111111;
        default: want = 7'b1111000;
      endcase
      checks++;
      if (an === 4'b1111 || seg !== want) begin
        errors++; $display("FAIL static_slot an=%b seg=%b want seg %b", an, seg, want);
      end
    end
  endtask

  task automatic test_p2_flash();
    p2_score = 4'd8;
    for (int k = 0; k < 56; k++) begin
      step();
      checks++;
      if (an !== exp_an || (exp_an != 4'hF && seg !== exp_seg)) begin
        errors++; $display("FAIL p2_flash cyc=%0d an=%b seg=%b want %b %b", cyc, an, seg, exp_an, exp_seg);
      end
    end
  endtask

  task automatic test_glitch();
    p1_score = 4'd5;
    step();
    p1_score = 4'd3;
    for (int k = 0; k < 40; k++) begin
      step();
      checks++;
      if (an !== exp_an || (exp_an != 4'hF && seg !== exp_seg)) begin
        errors++; $display("FAIL glitch cyc=%0d an=%b seg=%b want %b %b", cyc, an, seg, exp_an, exp_seg);
      end
      if (an === 4'b0111 || (((cyc - 1) / SD) % 4) == 3) begin
        checks++;
        if (an !== 4'b0111 || seg !== 7'b0110000) begin
          errors++; $display("FAIL glitch_p1 an=%b seg=%b want 0111 0110000", an, seg);
        end
      end
    end
  endtask

  task automatic test_error_simul();
    p1_score = 4'd12;
    for (int k = 0; k < 48; k++) begin
      step();
      checks++;
      if (an !== exp_an || (exp_an != 4'hF && seg !== exp_seg)) begin
        errors++; $display("FAIL err_digit cyc=%0d an=%b seg=%b want %b %b", cyc, an, seg, exp_an, exp_seg);
      end
      if (k >= 8 && an === 4'b0111) begin
        checks++;
        if (seg !== 7'b0000110) begin
          errors++; $display("FAIL err_E seg=%b want 0000110", seg);
        end
      end
    end
    p1_score = 4'd4; p2_score = 4'd2;
    for (int k = 0; k < 48; k++) begin
      step();
      checks++;
      if (an !== exp_an || (exp_an != 4'hF && seg !== exp_seg)) begin
        errors++; $display("FAIL lockstep cyc=%0d an=%b seg=%b want %b %b", cyc, an, seg, exp_an, exp_seg);
      end
    end
  endtask

  task automatic test_enable();
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if (an !== 4'b1111 || exp_an !== 4'b1111) begin
        errors++; $display("FAIL en_off k=%0d an=%b want 1111", k, an);
      end
    end
    en = 1'b1;
    for (int k = 0; k < 24; k++) begin
      step();
      checks++;
      if (an !== exp_an || (exp_an != 4'hF && seg !== exp_seg)) begin
        errors++; $display("FAIL en_on cyc=%0d an=%b seg=%b want %b %b", cyc, an, seg, exp_an, exp_seg);
      end
    end
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    for (int k = 0; k < 900; k++) begin
      if (hold == 0) begin
        if ($urandom_range(0, 1) == 1) p1_score = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 1) == 1) p2_score = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 9) == 0) en = ~en;
        hold = $urandom_range(0, 3) == 0 ? 1 : $urandom_range(2, 40);
      end
      hold--;
      step();
      checks++;
      if (an !== exp_an || (exp_an != 4'hF && seg !== exp_seg) || dp !== 1'b1) begin
        errors++; $display("FAIL random cyc=%0d an=%b seg=%b want %b %b", cyc, an, seg, exp_an, exp_seg);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    model_reset();
    test_reset();
    test_static();
    test_p2_flash();
    test_glitch();
    test_error_simul();
    test_enable();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
